pipelined_csel_subtractor: RTL and testbench



---
 rtl/pipelined_csel_subtractor_pkg.sv | 23 ++
 rtl/carry_select_adder.sv | 29 ++
 rtl/pipelined_csel_subtractor.sv | 138 +++++++++++++
 tb/tb_pipelined_csel_subtractor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipelined_csel_subtractor_pkg.sv
// Shared constants and types for the pipelined carry-select subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipelined_csel_subtractor_pkg;

  // Default datapath width; must be even and at least 4.
  localparam int DEF_WIDTH = 32;

  // Bits handled by each pipeline stage.
  function automatic int half_width(input int w);
    return w / 2;
  endfunction

  localparam int DEF_LO = half_width(DEF_WIDTH);

  // Result beat at the default width, for consumers of the unit.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] diff;
    logic                 bout;
    logic                 ovf;
  } result_t;

endpackage

// File: rtl/carry_select_adder.sv
// Carry-select adder: sum = a + b + cin, upper half precomputed for both carries.
// Latency: combinational.
// Backpressure: none (pure datapath).
module carry_select_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int H = WIDTH / 2;
  localparam int U = WIDTH - H;

  logic [H:0] lo_sum;
  logic [U:0] hi_sum0;
  logic [U:0] hi_sum1;

  assign lo_sum  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
  assign hi_sum0 = {1'b0, a[WIDTH-1:H]} + {1'b0, b[WIDTH-1:H]};
  // Adding one cannot overflow U+1 bits: the largest hi_sum0 is 2^(U+1)-2.
  assign hi_sum1 = hi_sum0 + {{U{1'b0}}, 1'b1};

  assign {cout, sum} = lo_sum[H] ? {hi_sum1, lo_sum[H-1:0]}
                                 : {hi_sum0, lo_sum[H-1:0]};

endmodule

// File: rtl/pipelined_csel_subtractor.sv
// Two-stage subtractor diff = a - b - bin with borrow-out and signed overflow.
// Latency: 2 cycles from accept to out_valid; one result per cycle when unstalled.
// Backpressure: out_ready low holds the output; in_ready drops once stage 1 is full.
module pipelined_csel_subtractor
  import pipelined_csel_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int LO = half_width(WIDTH);

  // Stage-1 bank: finished low half plus the operands the high half still needs.
  typedef struct packed {
    logic [LO-1:0] d_lo;
    logic          c_mid;
    logic [LO-1:0] a_hi;
    logic [LO-1:0] nb_hi;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } res_t;

  s1_t  s1_q;
  logic s1_valid;
  res_t res_q;
  logic res_valid;

  logic s2_ready;
  logic s1_adv;
  logic accept;

  // a - b - bin is computed as a + ~b + ~bin; the low half runs in stage 1.
  logic [LO-1:0] lo_sum;
  logic          lo_cout;

  carry_select_adder #(.WIDTH(LO)) u_lo (
    .a    (a[LO-1:0]),
    .b    (~b[LO-1:0]),
    .cin  (~bin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // High half precomputed for both carry-ins; the registered c_mid picks one.
  logic [LO-1:0] hi_sum0;
  logic [LO-1:0] hi_sum1;
  logic          hi_cout0;
  logic          hi_cout1;

  carry_select_adder #(.WIDTH(LO)) u_hi0 (
    .a    (s1_q.a_hi),
    .b    (s1_q.nb_hi),
    .cin  (1'b0),
    .sum  (hi_sum0),
    .cout (hi_cout0)
  );

  carry_select_adder #(.WIDTH(LO)) u_hi1 (
    .a    (s1_q.a_hi),
    .b    (s1_q.nb_hi),
    .cin  (1'b1),
    .sum  (hi_sum1),
    .cout (hi_cout1)
  );

  res_t          s2_next;
  logic [LO-1:0] d_hi;
  logic          c_out;

  // Select the high half and form the result flags for stage 2.
  always_comb begin
    d_hi           = s1_q.c_mid ? hi_sum1  : hi_sum0;
    c_out          = s1_q.c_mid ? hi_cout1 : hi_cout0;
    s2_next        = '0;
    s2_next.diff   = {d_hi, s1_q.d_lo};
    // No carry out of a + ~b + ~bin means the subtraction borrowed.
    s2_next.bout   = ~c_out;
    // Overflow: operand signs differ and the result sign differs from a.
    s2_next.ovf    = (s1_q.a_hi[LO-1] != ~s1_q.nb_hi[LO-1]) &&
                     (d_hi[LO-1] != s1_q.a_hi[LO-1]);
  end

  assign s2_ready = !res_valid || out_ready;
  assign s1_adv   = s1_valid && s2_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign accept   = in_valid && in_ready;

  // Stage 1: capture low-half result and high-half operands on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (accept) begin
      s1_valid    <= 1'b1;
      s1_q.d_lo   <= lo_sum;
      s1_q.c_mid  <= lo_cout;
      s1_q.a_hi   <= a[WIDTH-1:LO];
      s1_q.nb_hi  <= ~b[WIDTH-1:LO];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: load the finished result; keep data after consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_q     <= '0;
    end else if (s1_adv) begin
      res_valid <= 1'b1;
      res_q     <= s2_next;
    end else if (out_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign out_valid = res_valid;
  assign diff      = res_q.diff;
  assign bout      = res_q.bout;
  assign ovf       = res_q.ovf;

endmodule

// File: tb/tb_pipelined_csel_subtractor.sv
// Directed bench for pipelined_csel_subtractor.
// Latency: checks the 2-cycle accept-to-result timing.
// Backpressure: exercises output stalls and mid-flight reset.
module tb_pipelined_csel_subtractor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;

  int n_chk;
  int n_pass;

  pipelined_csel_subtractor #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (diff !== 32'h0) $display("FAIL reset_diff: got %h want 0", diff); else n_pass++;
    n_chk++; if (bout !== 1'b0 || ovf !== 1'b0) $display("FAIL reset_flags: got bout=%b ovf=%b want 0 0", bout, ovf); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    step();
  endtask

  // One isolated beat: idle at N+1, result exactly at N+2.
  task automatic test_single(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                             input logic tbin, input logic [31:0] ed, input logic eb, input logic eo);
    out_ready = 1'b1;
    in_valid = 1'b1; a = ta; b = tb_; bin = tbin;
    step();
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; bin = ~tbin;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL %s_early: out_valid got %b want 0", name, out_valid); else n_pass++;
    step();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL %s_valid: out_valid got %b want 1", name, out_valid); else n_pass++;
    n_chk++; if (diff !== ed) $display("FAIL %s_diff: got %h want %h", name, diff, ed); else n_pass++;
    n_chk++; if (bout !== eb) $display("FAIL %s_bout: got %b want %b", name, bout, eb); else n_pass++;
    n_chk++; if (ovf !== eo) $display("FAIL %s_ovf: got %b want %b", name, ovf, eo); else n_pass++;
    step();
  endtask

  task automatic test_hold_after_consume();
    test_single("hold", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL hold_drop: out_valid got %b want 0", out_valid); else n_pass++;
    n_chk++; if (diff !== 32'h0000_0002) $display("FAIL hold_data: diff got %h want 00000002", diff); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea [8];
    int r;
    int p;
    for (int i = 0; i < 8; i++) ea[i] = 32'h1000_0000 + 32'(i) * 32'h100 - 32'(i & 1);
    r = 0; p = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      in_valid = (p < 8);
      a = 32'h1000_0000 + 32'(p) * 32'h101;
      b = 32'(p);
      bin = p[0];
      #1;
      if (cyc >= 2 && cyc < 10) begin
        n_chk++; if (out_valid !== 1'b1) $display("FAIL b2b_valid_c%0d: got %b want 1", cyc, out_valid); else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (r >= 8) $display("FAIL b2b_extra: got extra beat %h want none", diff);
        else if (diff !== ea[r]) $display("FAIL b2b_beat%0d: got %h want %h", r, diff, ea[r]);
        else n_pass++;
        r++;
      end
      if (in_valid && in_ready) p++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_chk++; if (r !== 8) $display("FAIL b2b_count: got %0d want 8", r); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] ta [3];
    logic [31:0] tbv [3];
    logic [31:0] ed [3];
    int r;
    int p;
    ta[0] = 32'h0000_0100; tbv[0] = 32'h0000_0001; ed[0] = 32'h0000_00FF;
    ta[1] = 32'h0000_0000; tbv[1] = 32'h0000_0002; ed[1] = 32'hFFFF_FFFE;
    ta[2] = 32'h8000_0000; tbv[2] = 32'h0000_0001; ed[2] = 32'h7FFF_FFFF;
    r = 0; p = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 5);
      in_valid = (p < 3);
      a = (p < 3) ? ta[p] : 32'h0;
      b = (p < 3) ? tbv[p] : 32'h0;
      bin = 1'b0;
      #1;
      if (cyc == 3 || cyc == 4) begin
        n_chk++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_c%0d: got %b want 0", cyc, in_ready); else n_pass++;
        n_chk++; if (out_valid !== 1'b1 || diff !== ed[0]) $display("FAIL stall_hold_c%0d: got v=%b %h want v=1 %h", cyc, out_valid, diff, ed[0]); else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (r >= 3) $display("FAIL stall_extra: got extra beat %h want none", diff);
        else if (diff !== ed[r]) $display("FAIL stall_beat%0d: got %h want %h", r, diff, ed[r]);
        else n_pass++;
        r++;
      end
      if (in_valid && in_ready) p++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_chk++; if (r !== 3 || p !== 3) $display("FAIL stall_count: got rx=%0d tx=%0d want 3 3", r, p); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h0000_0009; b = 32'h0000_0001; bin = 1'b0;
    step();
    a = 32'h8000_0000; b = 32'h0000_0001;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (diff !== 32'h0 || bout !== 1'b0 || ovf !== 1'b0) $display("FAIL rstmid_data: got %h %b %b want 0 0 0", diff, bout, ovf); else n_pass++;
    step();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_ghost: got %b want 0", out_valid); else n_pass++;
    test_single("post_rst", 32'h0000_0010, 32'h0000_0010, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    test_reset();
    test_hold_after_consume();
    test_single("zero_m1",     32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    test_single("zero_m1_bin", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    test_single("min_m1",      32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    test_single("max_mneg1",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
    test_single("cross",       32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
    test_single("bin_only",    32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
